// File: rtl/drp_seq_pkg.sv
// rtl/drp_seq_pkg.sv - shared types, default XADC addresses and helpers for the DRP channel sequencer
package drp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT_READY,
        ST_PUBLISH
    } seq_state_t;

    localparam int MAX_CHANNELS = 16;

    localparam logic [6:0] XADC_VAUX2  = 7'h12;
    localparam logic [6:0] XADC_VAUX3  = 7'h13;
    localparam logic [6:0] XADC_VAUX10 = 7'h1A;
    localparam logic [6:0] XADC_VAUX11 = 7'h1B;

    localparam logic [27:0] DEFAULT_CHANNEL_ADDRESSES =
        {XADC_VAUX11, XADC_VAUX3, XADC_VAUX10, XADC_VAUX2};

    typedef struct packed {
        logic       found;
        logic [3:0] index;
    } idx_search_t;

    // Lowest set bit of mask at or above position 'from'.
    function automatic idx_search_t next_enabled_index(input logic [MAX_CHANNELS-1:0] mask,
                                                       input logic [4:0]              from);
        idx_search_t result;
        result.found = 1'b0;
        result.index = 4'd0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                result.found = 1'b1;
                result.index = 4'(i);
            end
        end
        return result;
    endfunction

    // Left-justified sample: the top sample_bits of a drp_bits-wide word.
    function automatic logic [31:0] extract_sample(input logic [31:0] drp_data,
                                                   input int          drp_bits,
                                                   input int          sample_bits);
        logic [31:0] keep;
        keep = (sample_bits >= 32) ? '1 : ((32'd1 << sample_bits) - 32'd1);
        return (drp_data >> (drp_bits - sample_bits)) & keep;
    endfunction

endpackage

// File: rtl/drp_read_timer.sv
// rtl/drp_read_timer.sv - load/run down-counter that flags an expired DRP read wait
module drp_read_timer #(
    parameter int CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] r_count;

    // Loaded with CYCLES-1 so that the CYCLES-th waiting cycle sees zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(CYCLES - 1);
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = i_run && (r_count == '0);

endmodule

// File: rtl/drp_channel_sequencer.sv
// rtl/drp_channel_sequencer.sv - EOC-triggered multi-channel DRP reader with atomic publish; DRP_SEQ_TIMEOUT_EN adds a DRP-ready timeout
module drp_channel_sequencer
    import drp_seq_pkg::*;
#(
    parameter int NUM_CHANNELS     = 4,
    parameter int SAMPLE_BITS      = 12,
    parameter int DRP_DATA_BITS    = 16,
    parameter int DRP_ADDRESS_BITS = 7,
    parameter logic [NUM_CHANNELS*DRP_ADDRESS_BITS-1:0] CHANNEL_ADDRESSES = DEFAULT_CHANNEL_ADDRESSES,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                endOfConversion,
    input  logic [NUM_CHANNELS-1:0]             channelEnable,
    input  logic                                DRPReady,
    input  logic [DRP_DATA_BITS-1:0]            DRPDataOut,
    output logic                                DRPEnable,
    output logic                                DRPWriteEnable,
    output logic [DRP_ADDRESS_BITS-1:0]         DRPAddress,
    output logic [NUM_CHANNELS*SAMPLE_BITS-1:0] channelData,
    output logic [NUM_CHANNELS-1:0]             frameValidMask,
    output logic                                channelDataReady,
    output logic [7:0]                          overrunCount,
    output logic                                timeoutError
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    seq_state_t                        r_state;
    seq_state_t                        w_state_next;
    logic [IDX_W-1:0]                  r_index;
    logic [IDX_W-1:0]                  w_index_next;
    logic [NUM_CHANNELS-1:0]           r_active_mask;
    logic [NUM_CHANNELS-1:0]           w_active_mask_next;
    logic [NUM_CHANNELS-1:0]           r_shadow_valid;
    logic [NUM_CHANNELS-1:0]           w_shadow_valid_next;
    logic [SAMPLE_BITS-1:0]            r_shadow [NUM_CHANNELS];
    logic [NUM_CHANNELS*SAMPLE_BITS-1:0] r_channel_data;
    logic [NUM_CHANNELS*SAMPLE_BITS-1:0] w_merged_data;
    logic [NUM_CHANNELS-1:0]           r_frame_valid_mask;
    logic [7:0]                        r_overrun_count;

    logic                              w_start;
    logic                              w_capture;
    logic                              w_overrun;
    logic                              w_timer_expired;
    idx_search_t                       w_first;
    idx_search_t                       w_next;
    logic [SAMPLE_BITS-1:0]            w_sample;

    assign w_first  = next_enabled_index(MAX_CHANNELS'(channelEnable), 5'd0);
    assign w_next   = next_enabled_index(MAX_CHANNELS'(r_active_mask), 5'(r_index) + 5'd1);
    assign w_sample = SAMPLE_BITS'(extract_sample(32'(DRPDataOut), DRP_DATA_BITS, SAMPLE_BITS));

    always_comb begin
        w_state_next        = r_state;
        w_index_next        = r_index;
        w_active_mask_next  = r_active_mask;
        w_shadow_valid_next = r_shadow_valid;
        w_start             = 1'b0;
        w_capture           = 1'b0;
        w_overrun           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_start = endOfConversion;
            end
            ST_REQUEST: begin
                if (endOfConversion) begin
                    w_start   = 1'b1;
                    w_overrun = 1'b1;
                end else begin
                    w_state_next = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                // An EOC here wins over a coincident DRPReady: the frame is abandoned.
                if (endOfConversion) begin
                    w_start   = 1'b1;
                    w_overrun = 1'b1;
                end else if (DRPReady || w_timer_expired) begin
                    if (DRPReady) begin
                        w_capture                    = 1'b1;
                        w_shadow_valid_next[r_index] = 1'b1;
                    end
                    if (w_next.found) begin
                        w_state_next = ST_REQUEST;
                        w_index_next = IDX_W'(w_next.index);
                    end else begin
                        w_state_next = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                w_shadow_valid_next = '0;
                w_state_next        = ST_IDLE;
                w_start             = endOfConversion;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_active_mask_next  = channelEnable;
            w_shadow_valid_next = '0;
            w_index_next        = IDX_W'(w_first.index);
            w_state_next        = w_first.found ? ST_REQUEST : ST_IDLE;
        end
    end

    always_comb begin
        w_merged_data = r_channel_data;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (r_shadow_valid[i]) begin
                w_merged_data[i*SAMPLE_BITS +: SAMPLE_BITS] = r_shadow[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_index            <= '0;
            r_active_mask      <= '0;
            r_shadow_valid     <= '0;
            r_channel_data     <= '0;
            r_frame_valid_mask <= '0;
            r_overrun_count    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state        <= w_state_next;
            r_index        <= w_index_next;
            r_active_mask  <= w_active_mask_next;
            r_shadow_valid <= w_shadow_valid_next;
            if (w_capture) begin
                r_shadow[r_index] <= w_sample;
            end
            if (w_overrun && (r_overrun_count != 8'hFF)) begin
                r_overrun_count <= r_overrun_count + 8'd1;
            end
            if (r_state == ST_PUBLISH) begin
                r_channel_data     <= w_merged_data;
                r_frame_valid_mask <= r_shadow_valid;
            end
        end
    end

`ifdef DRP_SEQ_TIMEOUT_EN
    logic w_timer_load;
    logic w_timer_run;
    logic w_timeout_hit;
    logic r_timeout_error;

    assign w_timer_load  = (r_state == ST_REQUEST);
    assign w_timer_run   = (r_state == ST_WAIT_READY);
    assign w_timeout_hit = w_timer_expired && !DRPReady && !endOfConversion;

    drp_read_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_read_timer (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_timer_load),
        .i_run     (w_timer_run),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout_error <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout_error <= 1'b1;
        end
    end

    assign timeoutError = r_timeout_error;
`else
    assign w_timer_expired = 1'b0;
    assign timeoutError    = 1'b0;
`endif

    // Publish-cycle outputs are combined so data and mask are valid with the pulse.
    assign channelDataReady = (r_state == ST_PUBLISH);
    assign channelData      = channelDataReady ? w_merged_data  : r_channel_data;
    assign frameValidMask   = channelDataReady ? r_shadow_valid : r_frame_valid_mask;
    assign overrunCount     = r_overrun_count;
    assign DRPEnable        = (r_state == ST_REQUEST);
    assign DRPWriteEnable   = 1'b0;
    assign DRPAddress       = DRPEnable ? CHANNEL_ADDRESSES[r_index*DRP_ADDRESS_BITS +: DRP_ADDRESS_BITS]
                                        : '0;

endmodule
